// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its PC helper.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_ERR   = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INCR       = 32'd4;
   localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
   localparam logic        PC_SEL_SEQ    = 1'b0;
   localparam logic        PC_SEL_BRANCH = 1'b1;
   localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential PC+4 or branch PC+4+Immed, always word aligned.
module pc_next_calc
   import if_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] immed_i,
   input  logic        pc_sel_i,
   output logic [31:0] pc_next_o
);

   logic [31:0] seq_s;
   logic [31:0] branch_s;
   logic [31:0] sel_s;

   // Both candidates are formed in parallel; Immed low bits never reach the PC.
   always_comb begin
      seq_s    = pc_i + PC_INCR;
      branch_s = seq_s + (immed_i & WORD_MASK);
      case (pc_sel_i)
         PC_SEL_BRANCH: sel_s = branch_s;
         PC_SEL_SEQ:    sel_s = seq_s;
         default:       sel_s = seq_s;
      endcase
      pc_next_o = sel_s & WORD_MASK;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and
// presents the word to decode; raises a sticky error if memory never answers.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        PC_LdEn,
   input  logic        PC_sel,
   input  logic [31:0] Immed,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic [31:0] Imem_rdata,
   input  logic        Imem_ack,
   output logic [31:0] Instr,
   output logic        Instr_valid,
   output logic [31:0] PC,
   output logic        Fetch_err
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             req_q, req_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pc_next_s;

   pc_next_calc u_pc_next (
      .pc_i      (pc_q),
      .immed_i   (Immed),
      .pc_sel_i  (PC_sel),
      .pc_next_o (pc_next_s)
   );

   // Next-state logic; req_q low in FETCH only happens on the first cycle after reset.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      req_d   = req_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FETCH: begin
            if (!req_q) begin
               req_d = 1'b1;
               cnt_d = {CNT_W{1'b0}};
            end else if (Imem_ack) begin
               instr_d = Imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_HOLD;
            end else if (cnt_q == WAIT_LAST) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_HOLD: begin
            if (PC_LdEn) begin
               pc_d    = pc_next_s;
               valid_d = 1'b0;
               req_d   = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_FETCH;
            end else begin
               req_d   = 1'b0;
               state_d = ST_HOLD;
            end
         end
         ST_ERR: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
         default: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            state_d = ST_FETCH;
         end
      endcase
   end

   // State and output registers; reset abandons any request immediately.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Imem_req    = req_q;
   assign Imem_addr   = pc_q;
   assign Instr       = instr_q;
   assign Instr_valid = valid_q;
   assign PC          = pc_q;
   assign Fetch_err   = err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scenario bench for if_fetch_unit: expected instruction words are queued when
// the ack is driven and popped when Instr_valid is observed.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned TMO    = 4;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        PC_LdEn = 1'b0;
   logic        PC_sel = 1'b0;
   logic [31:0] Immed = 32'h0;
   logic        Imem_req;
   logic [31:0] Imem_addr;
   logic [31:0] Imem_rdata = 32'h0;
   logic        Imem_ack = 1'b0;
   logic [31:0] Instr;
   logic        Instr_valid;
   logic [31:0] PC;
   logic        Fetch_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_pc;
   logic [31:0] held_instr;

   if_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel),
      .Immed(Immed), .Imem_req(Imem_req), .Imem_addr(Imem_addr),
      .Imem_rdata(Imem_rdata), .Imem_ack(Imem_ack), .Instr(Instr),
      .Instr_valid(Instr_valid), .PC(PC), .Fetch_err(Fetch_err)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic sel,
                                           input logic [31:0] imm);
      logic [31:0] n;
      n = pc + 32'd4;
      if (sel) n = n + {imm[31:2], 2'b00};
      return {n[31:2], 2'b00};
   endfunction

   task automatic apply_reset();
      Reset_n = 1'b0;
      PC_LdEn = 1'b0;
      Imem_ack = 1'b0;
      #1;
      checks++;
      if (Imem_req !== 1'b0 || PC !== RST_PC || Fetch_err !== 1'b0 || Instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async req=%b pc=%h err=%b valid=%b expected req=0 pc=%h err=0 valid=0",
                  Imem_req, PC, Fetch_err, Instr_valid, RST_PC);
      end
      tick();
      tick();
      Reset_n = 1'b1;
      model_pc = RST_PC;
      exp_q.delete();
   endtask

   // Waits for the request, stalls `waits` cycles (with junk control inputs), then acks.
   task automatic do_fetch(input logic [31:0] rdata, input int waits);
      int budget;
      budget = 0;
      while (Imem_req !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      checks++;
      if (Imem_req !== 1'b1 || Imem_addr !== model_pc) begin
         errors++;
         $display("FAIL fetch_req req=%b addr=%h expected req=1 addr=%h", Imem_req, Imem_addr, model_pc);
      end
      for (int w = 0; w < waits; w++) begin
         PC_LdEn = 1'b1;
         PC_sel  = 1'b1;
         Immed   = $urandom;
         tick();
         checks++;
         if (Imem_req !== 1'b1 || Imem_addr !== model_pc || PC !== model_pc || Instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait req=%b addr=%h pc=%h valid=%b expected req=1 addr=%h valid=0",
                     Imem_req, Imem_addr, PC, Instr_valid, model_pc);
         end
      end
      PC_LdEn = 1'b0;
      PC_sel  = 1'b0;
      exp_q.push_back(rdata);
      Imem_ack   = 1'b1;
      Imem_rdata = rdata;
      tick();
      Imem_ack   = 1'b0;
      Imem_rdata = $urandom;
      checks++;
      if (Instr_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL fetch_valid valid=%b queued=%0d expected valid=1", Instr_valid, exp_q.size());
      end else begin
         logic [31:0] e;
         e = exp_q.pop_front();
         checks++;
         if (Instr !== e || PC !== model_pc || Imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data instr=%h pc=%h req=%b expected instr=%h pc=%h req=0",
                     Instr, PC, Imem_req, e, model_pc);
         end
      end
   endtask

   task automatic do_advance(input logic sel, input logic [31:0] imm);
      model_pc = next_pc(model_pc, sel, imm);
      PC_LdEn = 1'b1;
      PC_sel  = sel;
      Immed   = imm;
      tick();
      PC_LdEn = 1'b0;
      PC_sel  = 1'b0;
      checks++;
      if (PC !== model_pc || Instr_valid !== 1'b0 || Imem_req !== 1'b1 || Imem_addr !== model_pc) begin
         errors++;
         $display("FAIL advance pc=%h valid=%b req=%b addr=%h expected pc=%h valid=0 req=1",
                  PC, Instr_valid, Imem_req, Imem_addr, model_pc);
      end
   endtask

   task automatic check_pc(input string name, input logic [31:0] want);
      checks++;
      if (PC !== want) begin
         errors++;
         $display("FAIL %s pc=%h expected %h", name, PC, want);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (Instr !== 32'h0 || Imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_state instr=%h req=%b expected instr=0 req=0", Instr, Imem_req);
      end
      tick();
      checks++;
      if (Imem_req !== 1'b1 || Imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL reset_first_req req=%b addr=%h expected req=1 addr=%h", Imem_req, Imem_addr, RST_PC);
      end
   endtask

   task automatic test_zero_wait();
      do_fetch(32'h3C01_0005, 0);
      check_pc("zero_wait_pc", 32'h0000_0000);
   endtask

   task automatic test_sequential();
      do_advance(1'b1, 32'h0000_000C);
      check_pc("branch_to_10", 32'h0000_0010);
      do_fetch(32'h1111_2222, 2);
      do_advance(1'b0, 32'hFFFF_FFFF);
      check_pc("seq_14", 32'h0000_0014);
      do_fetch(32'h3333_4444, 1);
   endtask

   task automatic test_branch();
      do_advance(1'b1, 32'h0000_00E8);
      check_pc("branch_to_100", 32'h0000_0100);
      do_fetch(32'h5555_6666, 3);
      do_advance(1'b1, 32'hFFFF_FFF8);
      check_pc("branch_back_fc", 32'h0000_00FC);
      do_fetch(32'h7777_8888, 0);
      do_advance(1'b1, 32'h0000_0013);
      check_pc("immed_low_bits", 32'h0000_0110);
      do_fetch(32'h0BAD_F00D, 0);
   endtask

   task automatic test_wrap();
      do_advance(1'b1, 32'hFFFF_FEE8);
      check_pc("branch_to_top", 32'hFFFF_FFFC);
      do_fetch(32'h9999_AAAA, 1);
      do_advance(1'b0, 32'h0);
      check_pc("wrap_zero", 32'h0000_0000);
      do_fetch(32'hCAFE_0001, 0);
   endtask

   task automatic test_stall();
      held_instr = 32'hCAFE_0001;
      for (int i = 0; i < 5; i++) begin
         PC_sel = 1'b1;
         Immed  = $urandom;
         tick();
         checks++;
         if (Instr !== held_instr || PC !== model_pc || Imem_req !== 1'b0 || Instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall instr=%h pc=%h req=%b valid=%b expected instr=%h pc=%h req=0 valid=1",
                     Instr, PC, Imem_req, Instr_valid, held_instr, model_pc);
         end
      end
      Imem_ack   = 1'b1;
      Imem_rdata = 32'hDEAD_BEEF;
      tick();
      Imem_ack = 1'b0;
      tick();
      checks++;
      if (Instr !== held_instr || Instr_valid !== 1'b1 || Imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack instr=%h valid=%b req=%b expected instr=%h valid=1 req=0",
                  Instr, Instr_valid, Imem_req, held_instr);
      end
   endtask

   task automatic test_timeout();
      do_advance(1'b0, 32'h0);
      for (int i = 1; i < TMO; i++) begin
         tick();
         checks++;
         if (Fetch_err !== 1'b0 || Imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait cycle=%0d err=%b req=%b expected err=0 req=1", i, Fetch_err, Imem_req);
         end
      end
      tick();
      checks++;
      if (Fetch_err !== 1'b1 || Imem_req !== 1'b0 || Instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err err=%b req=%b valid=%b expected err=1 req=0 valid=0",
                  Fetch_err, Imem_req, Instr_valid);
      end
      PC_LdEn  = 1'b1;
      Imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (Fetch_err !== 1'b1 || Imem_req !== 1'b0 || Instr_valid !== 1'b0 || PC !== model_pc) begin
            errors++;
            $display("FAIL err_sticky err=%b req=%b valid=%b pc=%h expected err=1 req=0 valid=0 pc=%h",
                     Fetch_err, Imem_req, Instr_valid, PC, model_pc);
         end
      end
      PC_LdEn  = 1'b0;
      Imem_ack = 1'b0;
      apply_reset();
   endtask

   task automatic test_reset_mid_wait();
      do_fetch(32'h1234_5678, 0);
      do_advance(1'b1, 32'h0000_003C);
      check_pc("branch_to_40", 32'h0000_0040);
      tick();
      tick();
      apply_reset();
      do_fetch(32'h8765_4321, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty left=%0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      model_pc = RST_PC;
      test_reset();
      test_zero_wait();
      test_sequential();
      test_branch();
      test_wrap();
      test_stall();
      test_timeout();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
